// File: rtl/lb_scale_reader.sv
// Framebuffer line reader with two line banks. While the front bank is replayed with
// horizontal replication, the next framebuffer row is prefetched into the back bank.
module lb_scale_reader #(
    parameter int CORDW     = 16,
    parameter int DATAW     = 4,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int SCALEW    = 6,
    parameter int BRAM_LAT  = 1,
    parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic [SCALEW-1:0]       scale_x,
    input  logic [SCALEW-1:0]       scale_y,
    input  logic signed [CORDW-1:0] origin_x,
    input  logic signed [CORDW-1:0] origin_y,
    output logic [FB_ADDRW-1:0]     fb_addr_read,
    input  logic [DATAW-1:0]        fb_colr_read,
    output logic [DATAW-1:0]        pix_colr,
    output logic                    pix_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int CW = $clog2(FB_WIDTH);
    localparam int RW = $clog2(FB_HEIGHT);
    localparam int DW = $clog2(BRAM_LAT+1);
    localparam logic [CW-1:0] COL_LAST = CW'(FB_WIDTH-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FB_HEIGHT-1);
    localparam logic [DW-1:0] DRN_LAST = DW'(BRAM_LAT-1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    function automatic logic [SCALEW-1:0] eff_scale(input logic [SCALEW-1:0] s);
        return (s == '0) ? SCALEW'(1) : s;
    endfunction

    state_t                    state_q, state_d;
    logic [SCALEW-1:0]         sxe_q, sye_q, sye_c;
    logic signed [CORDW-1:0]   ox_q, oy_q, oy_c, sy_nxt;
    logic [RW-1:0]             row_q, row_d;
    logic [SCALEW-1:0]         sub_q, sub_d;
    logic                      act_q, act_d, bank_q, bank_d, first_c, fill_c;
    logic [FB_ADDRW-1:0]       nbase_q, nbase_d, fbase_c, addr_q;
    logic [CW-1:0]             k_q;
    logic [DW-1:0]             dcnt_q;
    logic [BRAM_LAT-1:0]       wv_q;
    logic [CW-1:0]             wk_q [BRAM_LAT];
    logic [DATAW-1:0]          bank0 [FB_WIDTH];
    logic [DATAW-1:0]          bank1 [FB_WIDTH];
    logic                      abort_c, push_c, wr_c, ovr_set_c, busy_c, overrun_q;
    logic                      hstart_c, hon_c, hrun_q, hrun_d;
    logic [CW-1:0]             col_q, col_d, col_c;
    logic [SCALEW-1:0]         csub_q, csub_d, csub_c;
    logic [DATAW-1:0]          rd_p1_q, pix_colr_q;
    logic                      vld_p1_q, pix_valid_q;

    // A frame arriving with a line must be seen by that line's step, so use fresh config.
    assign sye_c     = frame ? eff_scale(scale_y) : sye_q;
    assign oy_c      = frame ? origin_y : oy_q;
    assign sy_nxt    = sy + CORDW'(1);
    assign fbase_c   = frame ? '0 : nbase_q;
    assign abort_c   = frame | line;
    assign ovr_set_c = line & ~frame & (state_q != IDLE);
    assign wr_c      = wv_q[BRAM_LAT-1] & ~abort_c;

    always_comb begin
        row_d   = frame ? '0 : row_q;
        sub_d   = frame ? '0 : sub_q;
        act_d   = frame ? 1'b0 : act_q;
        bank_d  = bank_q;
        first_c = 1'b0;
        fill_c  = 1'b0;
        if (line) begin
            if (sy == oy_c) begin
                row_d   = '0;
                sub_d   = '0;
                act_d   = 1'b1;
                first_c = 1'b1;
            end else if (act_d) begin
                if (sub_d == sye_c - SCALEW'(1)) begin
                    if (row_d == ROW_LAST) begin
                        act_d = 1'b0;
                    end else begin
                        row_d   = row_d + RW'(1);
                        sub_d   = '0;
                        first_c = 1'b1;
                    end
                end else begin
                    sub_d = sub_d + SCALEW'(1);
                end
            end
            if (first_c) bank_d = ~bank_q;
            if (sy_nxt == oy_c) fill_c = 1'b1;
            else if (act_d && (sub_d == sye_c - SCALEW'(1)) && (row_d != ROW_LAST)) fill_c = 1'b1;
        end
        nbase_d = fill_c ? fbase_c + FB_ADDRW'(FB_WIDTH) : fbase_c;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_c) begin
            state_d = fill_c ? FILL : IDLE;
        end else begin
            case (state_q)
                FILL:    if (k_q == COL_LAST) state_d = DRAIN;
                DRAIN:   if (dcnt_q == DRN_LAST) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_c = (state_q != IDLE);
        push_c = (state_q == FILL) && !abort_c;
    end

    always_comb begin
        hstart_c = act_q && (sx == ox_q);
        hon_c    = hstart_c | hrun_q;
        col_c    = hstart_c ? '0 : col_q;
        csub_c   = hstart_c ? '0 : csub_q;
        hrun_d   = hrun_q;
        col_d    = col_q;
        csub_d   = csub_q;
        if (abort_c) begin
            hrun_d = 1'b0;
            col_d  = '0;
            csub_d = '0;
        end else if (hon_c) begin
            if (csub_c == sxe_q - SCALEW'(1)) begin
                csub_d = '0;
                col_d  = (col_c == COL_LAST) ? '0 : col_c + CW'(1);
                hrun_d = (col_c != COL_LAST);
            end else begin
                csub_d = csub_c + SCALEW'(1);
                col_d  = col_c;
                hrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sxe_q <= SCALEW'(1);  sye_q <= SCALEW'(1);
            ox_q <= '0;  oy_q <= '0;
            row_q <= '0;  sub_q <= '0;  act_q <= 1'b0;  bank_q <= 1'b0;
            nbase_q <= '0;  addr_q <= '0;  k_q <= '0;  dcnt_q <= '0;  wv_q <= '0;
            overrun_q <= 1'b0;
            hrun_q <= 1'b0;  col_q <= '0;  csub_q <= '0;
            vld_p1_q <= 1'b0;  pix_valid_q <= 1'b0;  pix_colr_q <= '0;
        end else begin
            if (frame) begin
                sxe_q <= eff_scale(scale_x);
                sye_q <= eff_scale(scale_y);
                ox_q  <= origin_x;
                oy_q  <= origin_y;
            end
            row_q     <= row_d;
            sub_q     <= sub_d;
            act_q     <= act_d;
            bank_q    <= bank_d;
            nbase_q   <= nbase_d;
            overrun_q <= frame ? 1'b0 : (overrun_q | ovr_set_c);
            if (fill_c) begin
                addr_q <= fbase_c;
                k_q    <= '0;
            end else if (abort_c || (state_q == FILL && k_q == COL_LAST)) begin
                addr_q <= '0;
                k_q    <= '0;
            end else if (state_q == FILL) begin
                addr_q <= addr_q + FB_ADDRW'(1);
                k_q    <= k_q + CW'(1);
            end
            dcnt_q  <= (state_q == DRAIN && !abort_c) ? dcnt_q + DW'(1) : '0;
            wv_q[0] <= push_c;
            for (int i = 1; i < BRAM_LAT; i++) wv_q[i] <= wv_q[i-1] & ~abort_c;
            hrun_q <= hrun_d;
            col_q  <= col_d;
            csub_q <= csub_d;
            // Output stage: bank read registered in p1, masked pixel registered in p2.
            vld_p1_q    <= hon_c;
            pix_valid_q <= vld_p1_q;
            pix_colr_q  <= vld_p1_q ? rd_p1_q : '0;
        end
    end

    always_ff @(posedge clk_pix) begin
        wk_q[0] <= k_q;
        for (int i = 1; i < BRAM_LAT; i++) wk_q[i] <= wk_q[i-1];
        if (wr_c) begin
            if (bank_q) bank0[wk_q[BRAM_LAT-1]] <= fb_colr_read;
            else        bank1[wk_q[BRAM_LAT-1]] <= fb_colr_read;
        end
        rd_p1_q <= bank_q ? bank1[col_c] : bank0[col_c];
    end

    assign fb_addr_read = addr_q;
    assign pix_colr     = pix_colr_q;
    assign pix_valid    = pix_valid_q;
    assign busy         = busy_c;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_lb_scale_reader.sv
// Directed bench for lb_scale_reader: drives shortened display lines and compares
// every pixel against a window/scale model, plus fill address, overrun and reset checks.
module tb_lb_scale_reader;
    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    logic frame = 1'b0, line = 1'b0;
    logic signed [15:0] sx = '0, sy = '0, origin_x = '0, origin_y = '0;
    logic [5:0] scale_x = 6'd1, scale_y = 6'd1;
    logic [14:0] fb_addr_read;
    logic [3:0]  fb_colr_read, pix_colr;
    logic        pix_valid, busy, overrun;

    lb_scale_reader dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .line(line),
        .sx(sx), .sy(sy), .scale_x(scale_x), .scale_y(scale_y),
        .origin_x(origin_x), .origin_y(origin_y),
        .fb_addr_read(fb_addr_read), .fb_colr_read(fb_colr_read),
        .pix_colr(pix_colr), .pix_valid(pix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk_pix = ~clk_pix;

    // Framebuffer contents: row r, column c holds (r + c) mod 16 so rows differ.
    function automatic logic [3:0] fbval(input logic [14:0] a);
        int v;
        v = int'(a);
        return 4'((v + v / 160) % 16);
    endfunction

    always @(posedge clk_pix) fb_colr_read <= fbval(fb_addr_read);

    int n_tests = 0, n_fail = 0;
    int m_sxe = 1, m_sye = 1, m_ox = 0, m_oy = 0;
    bit chk_en = 1'b0;
    bit d1v = 0, d2v = 0, d1e = 0, d2e = 0;
    logic [3:0] d1c = '0, d2c = '0;
    int d1x = 0, d2x = 0, d1y = 0, d2y = 0;
    int n_busy, a_first, a_last, n_nz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model(input int x, input int y, output bit v, output logic [3:0] c);
        v = (y >= m_oy) && (y < m_oy + 120 * m_sye) && (x >= m_ox) && (x < m_ox + 160 * m_sxe);
        c = '0;
        if (v) c = fbval(15'(((y - m_oy) / m_sye) * 160 + (x - m_ox) / m_sxe));
    endfunction

    task automatic do_line(input int y, input int period, input bit lp, input bit fr, input int rst_at);
        bit nv;
        logic [3:0] nc;
        n_busy = 0; a_first = -1; a_last = -1; n_nz = 0;
        for (int c = 0; c < period; c++) begin
            @(negedge clk_pix);
            if (c == rst_at + 3) rst_pix = 1'b0;
            if (d2e) begin
                check($sformatf("pix_valid(%0d,%0d)", d2x, d2y), pix_valid, d2v);
                check($sformatf("pix_colr(%0d,%0d)", d2x, d2y), pix_colr, d2c);
            end
            if (busy) begin
                if (n_busy == 0)   a_first = fb_addr_read;
                if (n_busy == 159) a_last  = fb_addr_read;
                n_busy++;
            end
            if (fb_addr_read != 0) n_nz++;
            d2v = d1v; d2c = d1c; d2e = d1e; d2x = d1x; d2y = d1y;
            line  = lp && (c == 0);
            frame = fr && (c == 0);
            sx = 16'(c - 20);
            sy = 16'(y);
            if (frame) begin
                m_sxe = (scale_x == 0) ? 1 : int'(scale_x);
                m_sye = (scale_y == 0) ? 1 : int'(scale_y);
                m_ox  = int'(origin_x);
                m_oy  = int'(origin_y);
            end
            model(c - 20, y, nv, nc);
            d1v = nv; d1c = nc; d1e = chk_en; d1x = c - 20; d1y = y;
            if (c == rst_at) begin
                check("busy before reset", busy, 1);
                check("pix_valid before reset", pix_valid, 1);
                rst_pix = 1'b1;
                #1;
                check("busy async reset", busy, 0);
                check("fb_addr_read async reset", fb_addr_read, 0);
                check("pix_valid async reset", pix_valid, 0);
                check("pix_colr async reset", pix_colr, 0);
                chk_en = 1'b0; d1e = 0; d2e = 0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_pix);
        check("reset fb_addr_read", fb_addr_read, 0);
        check("reset pix_colr", pix_colr, 0);
        check("reset pix_valid", pix_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        rst_pix = 1'b0;

        // Scale 4/4 at origin (0,0); a mid-frame change to 2/2 only applies next frame.
        scale_x = 6'd4; scale_y = 6'd4; origin_x = 0; origin_y = 0; chk_en = 1'b1;
        for (int y = -2; y <= 1; y++) begin
            if (y == 0) begin scale_x = 6'd2; scale_y = 6'd2; origin_x = 16'sd5; end
            do_line(y, 700, 1'b1, y == -2, -1);
        end
        for (int y = -2; y <= 2; y++) do_line(y, 700, 1'b1, y == -2, -1);

        // Scale 2/3 at origin (16,8); row 1 is fetched during sy=10.
        scale_x = 6'd2; scale_y = 6'd3; origin_x = 16'sd16; origin_y = 16'sd8;
        for (int y = -2; y <= 13; y++) begin
            do_line(y, 400, 1'b1, y == -2, -1);
            if (y == 10) begin
                check("fill busy cycles sy10", n_busy, 161);
                check("fill first addr sy10", a_first, 160);
                check("fill last addr sy10", a_last, 319);
            end
        end

        // Zero scales behave as 1/1; row 119 lands on sy=121, nothing after.
        scale_x = 6'd0; scale_y = 6'd0; origin_x = 0; origin_y = 16'sd2;
        for (int y = -2; y <= 123; y++) do_line(y, 200, 1'b1, y == -2, -1);

        // Overrun: a line 100 cycles after the one that started a fill.
        scale_x = 6'd1; scale_y = 6'd1;
        for (int y = -2; y <= 0; y++) do_line(y, 200, 1'b1, y == -2, -1);
        do_line(1, 100, 1'b1, 1'b0, -1);
        check("overrun before short line", overrun, 0);
        chk_en = 1'b0;
        do_line(2, 200, 1'b1, 1'b0, -1);
        check("overrun set", overrun, 1);
        chk_en = 1'b1;
        do_line(3, 200, 1'b1, 1'b0, -1);
        check("overrun sticky", overrun, 1);
        do_line(4, 200, 1'b1, 1'b0, -1);
        do_line(-2, 200, 1'b1, 1'b1, -1);
        check("overrun cleared by frame", overrun, 0);

        // Reset in the middle of a fill while pixels are being shown.
        for (int y = -1; y <= 1; y++) do_line(y, 200, 1'b1, 1'b0, -1);
        do_line(2, 200, 1'b1, 1'b0, 100);
        do_line(3, 300, 1'b0, 1'b0, -1);
        check("no busy after reset release", n_busy, 0);
        check("no address after reset release", n_nz, 0);
        chk_en = 1'b1;
        for (int y = -2; y <= 4; y++) do_line(y, 200, 1'b1, y == -2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
